// File: rtl/mips16_mem_pkg.sv
// ---------------------------------------------------------------------------
// mips16_mem_pkg
// Shared definitions for the mips16 data-memory responder:
//   DATA_W / ADDR_W  : data and byte-address widths of the data port
//   dmem_state_t     : responder FSM states (IDLE -> WAIT -> RESP)
//   dmem_addr_err    : address check (misaligned or beyond the array)
// ---------------------------------------------------------------------------
package mips16_mem_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // A byte address is bad when it is odd, or when its halfword index
    // falls past the last word. The whole upper address is compared, so
    // large addresses never alias back into the array.
    function automatic logic dmem_addr_err(input logic [ADDR_W-1:0] addr,
                                           input logic [31:0]       depth_words);
        logic [31:0] w_idx;
        w_idx = 32'(addr[ADDR_W-1:1]);
        return addr[0] | (w_idx >= depth_words);
    endfunction

endpackage

// File: rtl/mips16_dmem_responder_if.sv
// ---------------------------------------------------------------------------
// mips16_dmem_responder_if
// Request/response bundle between a data-port requester and the responder.
//   req_valid/req_ready   : request handshake
//   req_write             : 1 = store, 0 = load
//   req_addr/req_wdata    : byte address and store data
//   resp_valid/resp_ready : response handshake
//   resp_rdata/resp_err   : load data and error flag
// Modports: master = requester (core / bus master), slave = responder.
// ---------------------------------------------------------------------------
interface mips16_dmem_responder_if;
    import mips16_mem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/mips16_dmem_array.sv
// ---------------------------------------------------------------------------
// mips16_dmem_array
// Single-port synchronous RAM, DEPTH_WORDS x 16, one-cycle registered read.
//   clk     : clock
//   i_en    : port enable (read and/or write this edge)
//   i_we    : write enable (valid with i_en)
//   i_addr  : word index
//   i_wdata : write data
//   o_rdata : read data, updated on enabled edges, held otherwise
// Contents are never cleared; the read register holds its value while the
// port is idle, which lets the responder present stable data in RESP.
// ---------------------------------------------------------------------------
module mips16_dmem_array
    import mips16_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
    logic [DATA_W-1:0] r_rdata;

    // Read-before-write on a store; the responder never exposes the read
    // value of a store, so the ordering is irrelevant to the requester.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mips16_dmem_responder.sv
// ---------------------------------------------------------------------------
// mips16_dmem_responder
// Memory-side responder for the mips16 data port. Accepts one load/store
// at a time, spends WAIT_STATES cycles in WAIT, performs the array access
// on the edge that enters RESP, then holds the response until it is taken.
//   clk      : clock, rising edge
//   reset_n  : synchronous active-low reset
//   bus      : request/response bundle (slave side)
// Parameters:
//   DEPTH_WORDS : number of 16-bit words in the array
//   WAIT_STATES : cycles spent in WAIT (0 = access on the accept edge)
// Timing: accept edge -> resp_valid after WAIT_STATES+1 cycles (counting
// the accept cycle); one request per WAIT_STATES+2 cycles back to back.
// ---------------------------------------------------------------------------
module mips16_dmem_responder
    import mips16_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    mips16_dmem_responder_if.slave   bus
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (WAIT_STATES < 2) ? 1 : $clog2(WAIT_STATES + 1);

    // State and captured request
    dmem_state_t       r_state;
    dmem_state_t       w_state_next;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_next;
    logic              r_write;
    logic              w_write_next;
    logic [AW-1:0]     r_idx;
    logic [AW-1:0]     w_idx_next;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] w_wdata_next;
    logic              r_err;
    logic              w_err_next;

    // Array port
    logic              w_ram_en;
    logic              w_ram_we;
    logic [AW-1:0]     w_ram_addr;
    logic [DATA_W-1:0] w_ram_wdata;
    logic [DATA_W-1:0] w_ram_rdata;

    logic              w_in_err;
    logic              w_resp;

    assign w_in_err = dmem_addr_err(bus.req_addr, 32'(DEPTH_WORDS));

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_write <= w_write_next;
            r_idx   <= w_idx_next;
            r_wdata <= w_wdata_next;
            r_err   <= w_err_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next state, capture and array control
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_write_next = r_write;
        w_idx_next   = r_idx;
        w_wdata_next = r_wdata;
        w_err_next   = r_err;
        w_ram_en     = 1'b0;
        w_ram_we     = 1'b0;
        w_ram_addr   = r_idx;
        w_ram_wdata  = r_wdata;

        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    w_write_next = bus.req_write;
                    w_idx_next   = bus.req_addr[AW:1];
                    w_wdata_next = bus.req_wdata;
                    w_err_next   = w_in_err;
                    if (WAIT_STATES == 0) begin
                        // No wait states: the accept edge is also the
                        // access edge, so the array is fed from the bus.
                        w_ram_en     = !w_in_err;
                        w_ram_we     = bus.req_write & !w_in_err;
                        w_ram_addr   = bus.req_addr[AW:1];
                        w_ram_wdata  = bus.req_wdata;
                        w_state_next = RESP;
                    end else begin
                        w_cnt_next   = CW'(WAIT_STATES);
                        w_state_next = WAIT;
                    end
                end
            end

            WAIT: begin
                w_cnt_next = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    // Last wait cycle: this edge commits the store or
                    // samples the load, and the FSM enters RESP.
                    w_ram_en     = !r_err;
                    w_ram_we     = r_write & !r_err;
                    w_state_next = RESP;
                end
            end

            RESP: begin
                if (bus.resp_ready) begin
                    w_state_next = IDLE;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Storage. Gating with reset_n keeps a request that is being reset
    // away from committing on the same edge.
    // -----------------------------------------------------------------------
    mips16_dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk     (clk),
        .i_en    (w_ram_en & reset_n),
        .i_we    (w_ram_we & reset_n),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    // -----------------------------------------------------------------------
    // Outputs. The array is idle throughout RESP, so its read register
    // holds the loaded word; stores, errors and non-RESP cycles read as 0.
    // -----------------------------------------------------------------------
    assign w_resp         = (r_state == RESP);
    assign bus.req_ready  = (r_state == IDLE);
    assign bus.resp_valid = w_resp;
    assign bus.resp_err   = w_resp & r_err;
    assign bus.resp_rdata = (w_resp && !r_write && !r_err) ? w_ram_rdata : '0;

endmodule
